// File: rtl/priority_encoder_serial_if.sv
// Handshake bundle for priority_encoder_serial: vector input side and serial index output side.
// The slave modport is the encoder; the master modport is the producer/consumer around it.
interface priority_encoder_serial_if #(
    parameter int WIDTH = 8
) ();
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             zero;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output zero,
        output busy
    );

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  zero,
        input  busy
    );
endinterface

// File: rtl/priority_encoder_serial.sv
// Serial priority encoder: latches a multi-hot vector and drains its set-bit indices one per handshake.
// Define PRIO_ENC_LSB_FIRST_EN to drain lowest index first instead of highest.
module priority_encoder_serial #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    priority_encoder_serial_if.slave bus
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             zero_q, zero_d;

    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] clearMask;
    logic             onlyOne;
    logic             outFire;
    logic             accept;

    // Pick the winning pending bit; later loop iterations override earlier ones.
    always_comb begin
        idx = '0;
`ifdef PRIO_ENC_LSB_FIRST_EN
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) idx = IDXW'(i);
        end
`else
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) idx = IDXW'(i);
        end
`endif
        clearMask      = '0;
        clearMask[idx] = 1'b1;
        onlyOne = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    end

    assign bus.out_valid = (state_q == SCAN);
    assign bus.busy      = (state_q == SCAN);
    assign bus.out_idx   = idx;
    assign bus.out_last  = onlyOne;
    assign bus.zero      = zero_q;
    assign bus.in_ready  = (state_q == IDLE) || (bus.out_valid && bus.out_ready && onlyOne);

    assign outFire = bus.out_valid && bus.out_ready;
    assign accept  = bus.in_valid && bus.in_ready;

    // A new accept wins over the drain of the final bit, giving bubble-free back-to-back vectors.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = 1'b0;
        if (outFire) begin
            pending_d = pending_q & ~clearMask;
            if (onlyOne) state_d = IDLE;
        end
        if (accept) begin
            if (bus.in_vec != '0) begin
                pending_d = bus.in_vec;
                state_d   = SCAN;
            end else begin
                pending_d = '0;
                state_d   = IDLE;
                zero_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end
endmodule

// File: doc/priority_encoder_serial.md
Name: priority_encoder_serial

Overview:
Parametrised successor to the team's 4-bit combinational priority encoder. Accepts a WIDTH-bit request vector through a valid/ready handshake and holds it internally. It then emits the index of every set bit, one per output handshake, highest index first, clearing each bit as it is consumed. Used wherever a multi-hot vector (IRQ lines, dirty flags, pending requests) must be drained serially into a single-index consumer.

Parameters:
WIDTH, 8, request vector width; legal range 2..256; need not be a power of two.
IDXW, $clog2(WIDTH), index width; localparam, not overridable.

Ports:
clk       input   1      rising-edge clock
rst       input   1      synchronous, active-high reset
in_valid  input   1      in_vec is presented
in_ready  output  1      block can accept a vector this cycle
in_vec    input   WIDTH  request vector
out_valid output  1      out_idx is valid
out_ready input   1      consumer accepts out_idx this cycle
out_idx   output  IDXW   index of the current highest-priority pending bit
out_last  output  1      out_idx is the final set bit of the current vector
zero      output  1      one-cycle pulse: the accepted vector was all-zero
busy      output  1      a vector is being drained (state == SCAN)

Behaviour:
- State and storage:
  - States: IDLE, SCAN.
  - Internal register pending[WIDTH-1:0].
- Reset (rst=1 at a clk edge):
  - state=IDLE, pending=0, zero=0.
  - Resulting outputs: out_valid=0, out_idx=0, out_last=0, busy=0, in_ready=1.
  - Reset overrides every other event in the same cycle, including a mid-scan reset; remaining bits are discarded.
- Output decoding (from registered state/pending, no input-to-output path except in_ready):
  - out_valid = (state==SCAN).
  - busy = out_valid.
  - out_idx = index of highest set bit of pending; 0 when pending==0.
  - out_last = exactly one bit of pending set.
- in_ready = (state==IDLE) OR (out_valid AND out_ready AND out_last). This allows back-to-back vectors with no bubble.
- Accept = in_valid AND in_ready:
  - in_vec != 0: pending <= in_vec, state <= SCAN. First out_valid/out_idx appear the following cycle (latency 1).
  - in_vec == 0: state <= IDLE, pending <= 0, zero <= 1 for exactly one cycle. out_valid never asserts.
- zero deasserts the cycle after any cycle without a zero-vector accept.
- Output handshake (out_valid AND out_ready):
  - Clears bit out_idx of pending.
  - If out_last and no accept in the same cycle: state <= IDLE.
  - If out_last and accept in the same cycle: the accept rules above apply, replacing pending.
- Stall (out_valid AND NOT out_ready): pending, out_idx and out_last hold stable; in_ready=0.
- in_valid while in_ready=0: ignored. in_vec is not sampled; the upstream source holds it.
- Throughput: one index per cycle while out_ready=1. A vector with k set bits occupies k cycles.

Optional Feature:
Macro PRIO_ENC_LSB_FIRST_EN.
- Defined: priority is inverted. out_idx = index of the lowest set bit of pending, so bits drain LSB first. All handshake, zero, out_last and reset behaviour is unchanged.
- Undefined (default): MSB-first, as above.
- Ports are identical in both builds.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1, in_vec=8'hFF -> out_valid=0, out_idx=0, out_last=0, zero=0, busy=0, in_ready=1 after release; nothing loaded.
2. Drain: WIDTH=8, accept in_vec=8'b1010_0100 with out_ready=1 -> out_idx 7,5,2 on three consecutive cycles starting 1 cycle after accept; out_last=1 only with idx 2; in_ready=1 on that cycle; busy drops next cycle.
3. Backpressure: same vector, out_ready=0 for 3 cycles while idx=5 is shown -> out_idx=5 and out_last=0 held stable, in_ready=0; idx 2 follows on the cycle after out_ready returns high.
4. Zero vector: accept 8'h00 -> zero=1 for exactly one cycle after accept, out_valid stays 0, in_ready stays 1.
5. Back-to-back and mid-scan reset:
   - Present 8'h01 with in_valid during the last beat of 8'h90 -> accepted that cycle; next cycle out_idx=0, out_last=1, no bubble.
   - Separately, assert rst while idx=7 of 8'h90 is shown -> next cycle out_valid=0; idx 4 is never emitted.
6. With PRIO_ENC_LSB_FIRST_EN defined: 8'b1010_0100 -> out_idx 2,5,7, out_last with 7. With WIDTH=5: in_vec=5'b10001 -> 0,4.
